// File: rtl/if_branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit counters, trained by ID-stage resolutions.
// Latency: prediction is combinational (0 cycles); updates visible next cycle; mispredict pulse 1 cycle after update.
// Backpressure: none; accepts one resolution per cycle whenever upd_valid is high.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_pc                           fetch PC to predict for
//   pred_hit/pred_taken/pred_target prediction for if_pc (all zero on a miss)
//   upd_valid/upd_pc/upd_taken/upd_target            resolved branch from ID
//   upd_pred_taken/upd_pred_target                   prediction that was made in IF
//   mispredict                      registered 1-cycle pulse per mispredicted resolution
//   branch_cnt/mispred_cnt          saturating performance counters
module if_branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             mispred_cond;

    assign rd_idx = if_pc[IDX_W+1:2];
    assign rd_tag = if_pc[31:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[31:IDX_W+2];

    // Reads see pre-update table contents; no write-to-read bypass.
    always_comb begin
        pred_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken  = pred_hit && ctr_q[rd_idx][1];
        pred_target = pred_hit ? target_q[rd_idx] : 32'h0;
    end

    always_comb begin
        wr_hit       = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        // A correct taken direction still mispredicts if the fetched target was wrong.
        mispred_cond = (upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            mispredict  <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            mispredict <= upd_valid && mispred_cond;
            if (upd_valid) begin
                if (branch_cnt != '1) begin
                    branch_cnt <= branch_cnt + CNT_ONE;
                end
                if (mispred_cond && (mispred_cnt != '1)) begin
                    mispred_cnt <= mispred_cnt + CNT_ONE;
                end

                if (wr_hit) begin
                    if (upd_taken) begin
                        target_q[wr_idx] <= upd_target;
                        if (ctr_q[wr_idx] != 2'b11) begin
                            ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                        end
                    end else if (ctr_q[wr_idx] != 2'b00) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                    end
                end else if (upd_taken) begin
                    // Allocate weakly-taken, evicting whatever aliased into this index.
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= wr_tag;
                    target_q[wr_idx] <= upd_target;
                    ctr_q[wr_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_branch_predictor.sv
module tb_if_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        mispredict;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        pred_hit4, pred_taken4;
    logic [31:0] pred_target4;
    logic        mispredict4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    if_branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    if_branch_predictor #(.IDX_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(pred_hit4), .pred_taken(pred_taken4), .pred_target(pred_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    // Drive one resolution for a single cycle; returns 1 time unit after the edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic probe(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0; if_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a <= 32'h3C; a += 4) begin
            probe(a);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== 34'h0) begin
                fails++;
                $display("FAIL reset_pred pc=%h: hit=%b taken=%b tgt=%h, required 0/0/0",
                         a, pred_hit, pred_taken, pred_target);
            end
        end
        checks++;
        if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || mispredict !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt: br=%0d mp=%0d mis=%b, required 0/0/0",
                     branch_cnt, mispred_cnt, mispredict);
        end
    endtask

    task automatic test_allocate;
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        checks++;
        if (mispredict !== 1'b1 || branch_cnt !== 16'd1 || mispred_cnt !== 16'd1) begin
            fails++;
            $display("FAIL alloc_cnt: mis=%b br=%0d mp=%0d, required 1/1/1",
                     mispredict, branch_cnt, mispred_cnt);
        end
        probe(32'h0040_0010);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h0040_0100) begin
            fails++;
            $display("FAIL alloc_pred: hit=%b taken=%b tgt=%h, required 1/1/00400100",
                     pred_hit, pred_taken, pred_target);
        end
        @(posedge clk); #1;
        checks++;
        if (mispredict !== 1'b0) begin
            fails++;
            $display("FAIL mispredict_pulse: mis=%b, required 0", mispredict);
        end
    endtask

    task automatic test_counter_sat;
        // ctr 10 -> 11 -> 11 -> 11, all correctly predicted
        repeat (3) upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
        checks++;
        if (mispredict !== 1'b0 || branch_cnt !== 16'd4 || mispred_cnt !== 16'd1) begin
            fails++;
            $display("FAIL correct_pred_cnt: mis=%b br=%0d mp=%0d, required 0/4/1",
                     mispredict, branch_cnt, mispred_cnt);
        end
        // 11 -> 10: still taken (would read not-taken had the counter wrapped)
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        probe(32'h0040_0010);
        checks++;
        if (pred_taken !== 1'b1) begin
            fails++;
            $display("FAIL sat_hi_nt1: taken=%b, required 1", pred_taken);
        end
        // 10 -> 01
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        probe(32'h0040_0010);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin
            fails++;
            $display("FAIL sat_hi_nt2: hit=%b taken=%b, required 1/0", pred_hit, pred_taken);
        end
        // 01 -> 00 -> 00 -> 00, predicted not-taken correctly
        repeat (3) upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
        probe(32'h0040_0010);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h0040_0100) begin
            fails++;
            $display("FAIL sat_lo: hit=%b taken=%b tgt=%h, required 1/0/00400100",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if (branch_cnt !== 16'd9 || mispred_cnt !== 16'd3) begin
            fails++;
            $display("FAIL sat_cnt: br=%0d mp=%0d, required 9/3", branch_cnt, mispred_cnt);
        end
        // 00 -> 01: still not-taken, target overwritten
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        probe(32'h0040_0010);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0040_0200) begin
            fails++;
            $display("FAIL sat_lo_t1: taken=%b tgt=%h, required 0/00400200",
                     pred_taken, pred_target);
        end
        // 01 -> 10
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        probe(32'h0040_0010);
        checks++;
        if (pred_taken !== 1'b1) begin
            fails++;
            $display("FAIL sat_lo_t2: taken=%b, required 1", pred_taken);
        end
        // direction right, target wrong
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0300);
        checks++;
        if (mispredict !== 1'b1 || branch_cnt !== 16'd12 || mispred_cnt !== 16'd6) begin
            fails++;
            $display("FAIL target_mispred: mis=%b br=%0d mp=%0d, required 1/12/6",
                     mispredict, branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_alias;
        upd(32'h0040_0050, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
        probe(32'h0040_0010);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== 34'h0) begin
            fails++;
            $display("FAIL alias_old: hit=%b taken=%b tgt=%h, required 0/0/0",
                     pred_hit, pred_taken, pred_target);
        end
        probe(32'h0040_0050);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h0040_0500) begin
            fails++;
            $display("FAIL alias_new: hit=%b taken=%b tgt=%h, required 1/1/00400500",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_simultaneous;
        if_pc           = 32'h0040_0020;
        upd_valid       = 1'b1;
        upd_pc          = 32'h0040_0020;
        upd_taken       = 1'b1;
        upd_target      = 32'h0040_0400;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_read: hit=%b, required 0", pred_hit);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h0040_0400) begin
            fails++;
            $display("FAIL next_cycle_read: hit=%b tgt=%h, required 1/00400400",
                     pred_hit, pred_target);
        end
        // not-taken miss must not allocate
        upd(32'h0040_0030, 1'b0, 32'h0040_0700, 1'b0, 32'h0);
        probe(32'h0040_0030);
        checks++;
        if (pred_hit !== 1'b0 || mispredict !== 1'b0) begin
            fails++;
            $display("FAIL nt_miss: hit=%b mis=%b, required 0/0", pred_hit, mispredict);
        end
        checks++;
        if (branch_cnt !== 16'd15 || mispred_cnt !== 16'd8) begin
            fails++;
            $display("FAIL running_cnt: br=%0d mp=%0d, required 15/8", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_cnt_sat;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            upd(32'h0040_0070, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
        end
        checks++;
        if (branch_cnt4 !== 4'd15 || mispred_cnt4 !== 4'd15) begin
            fails++;
            $display("FAIL cnt4_sat: br=%0d mp=%0d, required 15/15", branch_cnt4, mispred_cnt4);
        end
        checks++;
        if (branch_cnt !== 16'd20 || mispred_cnt !== 16'd20) begin
            fails++;
            $display("FAIL cnt16_20: br=%0d mp=%0d, required 20/20", branch_cnt, mispred_cnt);
        end
        // reset coincides with an allocating, mispredicting update
        rst_n = 1'b0;
        upd(32'h0040_0070, 1'b1, 32'h0040_0800, 1'b0, 32'h0);
        rst_n = 1'b1;
        probe(32'h0040_0070);
        checks++;
        if (pred_hit !== 1'b0 || pred_hit4 !== 1'b0 || mispredict !== 1'b0 ||
            mispredict4 !== 1'b0) begin
            fails++;
            $display("FAIL rst_upd_drop: hit=%b hit4=%b mis=%b mis4=%b, required 0/0/0/0",
                     pred_hit, pred_hit4, mispredict, mispredict4);
        end
        checks++;
        if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 ||
            branch_cnt4 !== 4'd0 || mispred_cnt4 !== 4'd0) begin
            fails++;
            $display("FAIL rst_cnt: br=%0d mp=%0d br4=%0d mp4=%0d, required 0/0/0/0",
                     branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4);
        end
        @(posedge clk); #1;
        checks++;
        if (pred_hit !== 1'b0 || mispredict !== 1'b0 || branch_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rst_after: hit=%b mis=%b br=%0d, required 0/0/0",
                     pred_hit, mispredict, branch_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_allocate;
        test_counter_sat;
        test_alias;
        test_simultaneous;
        test_cnt_sat;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
